alu_issue_ctrl: RTL and testbench
=================================

// Module: alu_issue_ctrl
// PURPOSE
//  Control-side partner of the ALU. Accepts one 16-bit instruction per handshake and decodes it into ALU opcode and operands.
//  Captures the ALU result and flags, writes the result back to the register file, and holds the 5-bit PSR.
//  Sits between instruction fetch and the register file/ALU pair.
//  Multi-cycle and non-pipelined: one instruction in flight at a time.
// PARAMETERS
//  DATA_W   16  datapath width (fixed at 16; ALU contract)
//  REG_AW    4  register address width (16 registers)
// PORTS
//  clk          in   1   clock, rising edge
//  rst          in   1   synchronous, active-high reset
//  instr_valid  in   1   instruction offered
//  instr_ready  out  1   block can accept (high only in IDLE)
//  instr        in   16  [15:12] op, [11:8] Rdest, [7:4] ext or imm[7:4], [3:0] Rsrc or imm[3:0]
//  rf_raddr_a   out  4   read addr = Rdest
//  rf_raddr_b   out  4   read addr = Rsrc
//  rf_rdata_a   in   16  combinational read data for addr a
//  rf_rdata_b   in   16  combinational read data for addr b
//  alu_opcode   out  5   ALU opcode (ALU 5-bit encoding)
//  alu_rdest    out  16  ALU Rdest operand
//  alu_rsrc     out  16  ALU Rsrc operand (register value or extended immediate)
//  alu_out      in   16  ALU result (combinational)
//  alu_flags    in   5   ALU flags {N,Z,F,L,C} = [4:0]
//  rf_we        out  1   one-cycle write strobe
//  rf_waddr     out  4   write address
//  rf_wdata     out  16  write data
//  psr          out  5   processor status {N,Z,F,L,C}
//  illegal      out  1   one-cycle pulse on undecodable instruction
// BEHAVIOUR
//  Reset values: all outputs 0 except instr_ready=1; psr=0; FSM=IDLE.
//  FSM states: IDLE -> DECODE -> EXEC -> WB -> IDLE; illegal path is DECODE -> IDLE.
//  IDLE: instr_ready=1. On instr_valid&instr_ready, latch instr and go to DECODE (acceptance = cycle 0).
//  DECODE (cycle 1):
//   - Drive rf_raddr_a/b.
//   - Classify the instruction; register opcode and operands: alu_rdest=rf_rdata_a.
//   - alu_rsrc = rf_rdata_b (R-type) or extended imm8 (I-type).
//  EXEC (cycle 2):
//   - Hold the ALU inputs.
//   - Capture alu_out and alu_flags at the cycle end.
//  WB (cycle 3):
//   - rf_we=1 for non-compare ops, with rf_waddr=Rdest and rf_wdata=captured result.
//   - Update psr per class.
//   - Return to IDLE; ready again in cycle 4.
//  Decode table, R-type (op=0000, by ext):
//   0101 ADD->00000, 0110 ADDU->00010, 1001 SUB->01000, 1011 CMP->01010,
//   0001 AND->01101, 0010 OR->01110, 0011 XOR->01111.
//  Decode table, shifts (op=1000): ext 0100 LSH->10001, ext 0110 RSH->10011; alu_rsrc=Rdest value.
//  Decode table, I-type:
//   sign-extended imm8: 0101 ADDI->00001, 1001 SUBI->01001, 1011 CMPI->01011.
//   zero-extended imm8: 0110 ADDUI->00011, 0001 ANDI->01101, 0010 ORI->01110, 0011 XORI->01111.
//  Any other op/ext: illegal=1 in cycle 2 only; no rf_we; psr unchanged; back to IDLE.
//  PSR update rules:
//   - ADD/ADDU/SUB family: write C,F,Z.
//   - CMP/CMPI: write L,Z,N; rf_we stays 0.
//   - Logic and shift ops: psr unchanged.
//   - Bits not written keep their value.
//  Flow control: instr_valid held high while busy is ignored; no instruction is dropped or duplicated.
//  Reset in any state: next cycle IDLE, psr=0, no rf_we issued for the aborted instruction.
//  Widths: all arithmetic lives in the ALU; this block only extends imm8 to 16 bits (bit 7 replicated, or 8'h00).
// TESTING
//  1. R1=0005,R2=0003, instr 0x0152 (ADD R1,R2) -> alu_opcode 00000; cycle 3 rf_we=1, waddr=1, wdata=0008; psr C=F=Z=0.
//  2. instr 0x53FF (ADDI R3,-1) -> alu_rsrc=FFFF; instr 0x63FF (ADDUI) -> alu_rsrc=00FF.
//  3. R4=0001,R5=8000, instr 0x04B5 (CMP) -> rf_we never 1; psr L=1, N=0, Z=0; C,F unchanged.
//  4. instr 0xF000 -> illegal pulse in cycle 2, no rf_we, psr unchanged, instr_ready=1 in cycle 2.
//  5. rst asserted during EXEC of ADD -> IDLE next cycle, psr=00000, no rf_we pulse.
//  6. instr_valid held high across two ADDs -> acceptances exactly 4 cycles apart, two rf_we pulses.

Source files
------------

// File: rtl/alu_issue_ctrl_if.sv
// Instruction-issue bus between fetch, the issue controller, the register file
// and the ALU.
//
// Ports / signals:
//   instr_valid, instr_ready, instr     instruction handshake from fetch
//   rf_raddr_a/b, rf_rdata_a/b          register file read ports (combinational data)
//   alu_opcode, alu_rdest, alu_rsrc     operands presented to the ALU
//   alu_out, alu_flags                  combinational ALU result and {N,Z,F,L,C}
//   rf_we, rf_waddr, rf_wdata           register file write-back
//   psr                                 processor status {N,Z,F,L,C}
//   illegal                             one-cycle pulse for an undecodable instruction
//
// Modports:
//   slave  - the issue controller
//   master - the environment (fetch, register file and ALU)
interface alu_issue_ctrl_if #(
  parameter int DATA_W = 16,
  parameter int REG_AW = 4
);
  logic              instr_valid;
  logic              instr_ready;
  logic [15:0]       instr;
  logic [REG_AW-1:0] rf_raddr_a;
  logic [REG_AW-1:0] rf_raddr_b;
  logic [DATA_W-1:0] rf_rdata_a;
  logic [DATA_W-1:0] rf_rdata_b;
  logic [4:0]        alu_opcode;
  logic [DATA_W-1:0] alu_rdest;
  logic [DATA_W-1:0] alu_rsrc;
  logic [DATA_W-1:0] alu_out;
  logic [4:0]        alu_flags;
  logic              rf_we;
  logic [REG_AW-1:0] rf_waddr;
  logic [DATA_W-1:0] rf_wdata;
  logic [4:0]        psr;
  logic              illegal;

  modport slave (
    input  instr_valid, instr, rf_rdata_a, rf_rdata_b, alu_out, alu_flags,
    output instr_ready, rf_raddr_a, rf_raddr_b, alu_opcode, alu_rdest, alu_rsrc,
           rf_we, rf_waddr, rf_wdata, psr, illegal
  );

  modport master (
    output instr_valid, instr, rf_rdata_a, rf_rdata_b, alu_out, alu_flags,
    input  instr_ready, rf_raddr_a, rf_raddr_b, alu_opcode, alu_rdest, alu_rsrc,
           rf_we, rf_waddr, rf_wdata, psr, illegal
  );
endinterface

// File: rtl/alu_issue_ctrl.sv
// Issue controller for the 16-bit ALU. Accepts one instruction per handshake,
// decodes it into ALU opcode and operands, captures the ALU result and flags,
// writes the result back to the register file and maintains the PSR.
// Non-pipelined: IDLE -> DECODE -> EXEC -> WB -> IDLE, one instruction in flight.
//
// Ports:
//   clk  - rising-edge clock
//   rst  - synchronous, active-high reset
//   bus  - alu_issue_ctrl_if.slave (instruction handshake, register file
//          read/write ports, ALU operands/result, psr, illegal)
module alu_issue_ctrl #(
  parameter int DATA_W = 16,
  parameter int REG_AW = 4
) (
  input logic           clk,
  input logic           rst,
  alu_issue_ctrl_if.slave bus
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_DECODE = 2'd1;
  localparam logic [1:0] S_EXEC   = 2'd2;
  localparam logic [1:0] S_WB     = 2'd3;

  // PSR update class carried from decode to execute
  localparam logic [1:0] K_NONE  = 2'd0;
  localparam logic [1:0] K_ARITH = 2'd1;
  localparam logic [1:0] K_CMP   = 2'd2;

  logic [1:0]        state;
  logic [15:0]       instr_q;
  logic [1:0]        kind_q;
  logic [4:0]        opcode_q;
  logic [DATA_W-1:0] rdest_q;
  logic [DATA_W-1:0] rsrc_q;
  logic              rf_we_q;
  logic [REG_AW-1:0] rf_waddr_q;
  logic [DATA_W-1:0] rf_wdata_q;
  logic [4:0]        psr_q;
  logic              illegal_q;

  logic              dec_legal;
  logic [4:0]        dec_opcode;
  logic              dec_imm;
  logic              dec_sext;
  logic              dec_shift;
  logic [1:0]        dec_kind;
  logic [DATA_W-1:0] imm_ext;
  logic [DATA_W-1:0] rsrc_sel;

  // Instruction classification from the latched instruction word.
  // Shifts take their second operand from the Rdest register value.
  always_comb begin
    dec_legal  = 1'b0;
    dec_opcode = 5'b00000;
    dec_imm    = 1'b0;
    dec_sext   = 1'b0;
    dec_shift  = 1'b0;
    dec_kind   = K_NONE;
    case (instr_q[15:12])
      4'h0: begin
        dec_legal = 1'b1;
        case (instr_q[7:4])
          4'h5:    begin dec_opcode = 5'b00000; dec_kind = K_ARITH; end
          4'h6:    begin dec_opcode = 5'b00010; dec_kind = K_ARITH; end
          4'h9:    begin dec_opcode = 5'b01000; dec_kind = K_ARITH; end
          4'hB:    begin dec_opcode = 5'b01010; dec_kind = K_CMP;   end
          4'h1:    dec_opcode = 5'b01101;
          4'h2:    dec_opcode = 5'b01110;
          4'h3:    dec_opcode = 5'b01111;
          default: dec_legal = 1'b0;
        endcase
      end
      4'h8: begin
        dec_legal = 1'b1;
        dec_shift = 1'b1;
        case (instr_q[7:4])
          4'h4:    dec_opcode = 5'b10001;
          4'h6:    dec_opcode = 5'b10011;
          default: dec_legal = 1'b0;
        endcase
      end
      4'h5: begin dec_legal = 1'b1; dec_imm = 1'b1; dec_sext = 1'b1; dec_opcode = 5'b00001; dec_kind = K_ARITH; end
      4'h9: begin dec_legal = 1'b1; dec_imm = 1'b1; dec_sext = 1'b1; dec_opcode = 5'b01001; dec_kind = K_ARITH; end
      4'hB: begin dec_legal = 1'b1; dec_imm = 1'b1; dec_sext = 1'b1; dec_opcode = 5'b01011; dec_kind = K_CMP;   end
      4'h6: begin dec_legal = 1'b1; dec_imm = 1'b1; dec_opcode = 5'b00011; dec_kind = K_ARITH; end
      4'h1: begin dec_legal = 1'b1; dec_imm = 1'b1; dec_opcode = 5'b01101; end
      4'h2: begin dec_legal = 1'b1; dec_imm = 1'b1; dec_opcode = 5'b01110; end
      4'h3: begin dec_legal = 1'b1; dec_imm = 1'b1; dec_opcode = 5'b01111; end
      default: dec_legal = 1'b0;
    endcase
  end

  assign imm_ext  = dec_sext ? {{(DATA_W-8){instr_q[7]}}, instr_q[7:0]}
                             : {{(DATA_W-8){1'b0}}, instr_q[7:0]};
  assign rsrc_sel = dec_imm   ? imm_ext :
                    dec_shift ? bus.rf_rdata_a : bus.rf_rdata_b;

  // Main sequencer. rf_we and illegal default low so each is a single-cycle
  // strobe. Result and flags are taken at the end of EXEC so the write-back
  // and the new PSR are both visible during WB.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      instr_q    <= '0;
      kind_q     <= K_NONE;
      opcode_q   <= '0;
      rdest_q    <= '0;
      rsrc_q     <= '0;
      rf_we_q    <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
      psr_q      <= '0;
      illegal_q  <= 1'b0;
    end else begin
      rf_we_q   <= 1'b0;
      illegal_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.instr_valid) begin
            instr_q <= bus.instr;
            state   <= S_DECODE;
          end
        end
        S_DECODE: begin
          if (dec_legal) begin
            opcode_q <= dec_opcode;
            rdest_q  <= bus.rf_rdata_a;
            rsrc_q   <= rsrc_sel;
            kind_q   <= dec_kind;
            state    <= S_EXEC;
          end else begin
            illegal_q <= 1'b1;
            state     <= S_IDLE;
          end
        end
        S_EXEC: begin
          rf_we_q    <= (kind_q != K_CMP);
          rf_waddr_q <= instr_q[11:8];
          rf_wdata_q <= bus.alu_out;
          // psr bit order {N,Z,F,L,C}: arithmetic writes C,F,Z; compares write L,Z,N
          if (kind_q == K_ARITH) begin
            psr_q[0] <= bus.alu_flags[0];
            psr_q[2] <= bus.alu_flags[2];
            psr_q[3] <= bus.alu_flags[3];
          end else if (kind_q == K_CMP) begin
            psr_q[1] <= bus.alu_flags[1];
            psr_q[3] <= bus.alu_flags[3];
            psr_q[4] <= bus.alu_flags[4];
          end
          state <= S_WB;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.instr_ready = (state == S_IDLE);
  assign bus.rf_raddr_a  = instr_q[11:8];
  assign bus.rf_raddr_b  = instr_q[3:0];
  assign bus.alu_opcode  = opcode_q;
  assign bus.alu_rdest   = rdest_q;
  assign bus.alu_rsrc    = rsrc_q;
  assign bus.rf_we       = rf_we_q;
  assign bus.rf_waddr    = rf_waddr_q;
  assign bus.rf_wdata    = rf_wdata_q;
  assign bus.psr         = psr_q;
  assign bus.illegal     = illegal_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Self-checking bench for alu_issue_ctrl. The register file is a fixed
// read-only table; the ALU result and flags are supplied per vector so the
// controller's routing of results and PSR bits can be checked directly.
module tb_alu_issue_ctrl;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  alu_issue_ctrl_if bus ();

  alu_issue_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [15:0] instr;
    logic [15:0] alu_res;
    logic [4:0]  alu_flg;
    logic        illegal;
    logic [4:0]  opcode;
    logic [15:0] rdest;
    logic [15:0] rsrc;
    logic        we;
    logic [4:0]  psr;
  } vec_t;

  vec_t vecs [14];

  int checks = 0;
  int errors = 0;
  int cycle = 0;
  int accepts = 0;
  int we_count = 0;
  int accept_cycle [$];

  // Static register file contents
  function automatic logic [15:0] rf_val(input logic [3:0] a);
    case (a)
      4'd1:    rf_val = 16'h0005;
      4'd2:    rf_val = 16'h0003;
      4'd3:    rf_val = 16'h1234;
      4'd4:    rf_val = 16'h0001;
      4'd5:    rf_val = 16'h8000;
      default: rf_val = 16'h0000;
    endcase
  endfunction

  assign bus.rf_rdata_a = rf_val(bus.rf_raddr_a);
  assign bus.rf_rdata_b = rf_val(bus.rf_raddr_b);

  // Handshake and write-strobe monitor
  always @(posedge clk) begin
    cycle++;
    if (bus.instr_valid && bus.instr_ready) begin
      accepts++;
      accept_cycle.push_back(cycle);
    end
    if (bus.rf_we) we_count++;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Offers one instruction, then walks cycles 1..4 of its execution
  task automatic applyStimulus(input vec_t v, input int idx);
    int waited;
    string t;
    t = $sformatf("v%0d", idx);
    waited = 0;
    @(negedge clk);
    bus.alu_out     = v.alu_res;
    bus.alu_flags   = v.alu_flg;
    bus.instr       = v.instr;
    bus.instr_valid = 1'b1;
    while (!bus.instr_ready && waited < 10) begin
      @(negedge clk);
      waited++;
    end
    checkOutput({t, ".ready_c0"}, 16'(bus.instr_ready), 16'h0001);
    @(posedge clk);
    #1 bus.instr_valid = 1'b0;
    checkOutput({t, ".raddr_a"}, 16'(bus.rf_raddr_a), 16'(v.instr[11:8]));
    checkOutput({t, ".raddr_b"}, 16'(bus.rf_raddr_b), 16'(v.instr[3:0]));
    @(posedge clk);
    #1;
    checkOutput({t, ".illegal_c2"}, 16'(bus.illegal), 16'(v.illegal));
    checkOutput({t, ".we_c2"}, 16'(bus.rf_we), 16'h0000);
    if (v.illegal) begin
      checkOutput({t, ".ready_c2"}, 16'(bus.instr_ready), 16'h0001);
    end else begin
      checkOutput({t, ".opcode"}, 16'(bus.alu_opcode), 16'(v.opcode));
      checkOutput({t, ".rdest"}, bus.alu_rdest, v.rdest);
      checkOutput({t, ".rsrc"}, bus.alu_rsrc, v.rsrc);
    end
    @(posedge clk);
    #1;
    checkOutput({t, ".we_c3"}, 16'(bus.rf_we), 16'(v.we));
    checkOutput({t, ".illegal_c3"}, 16'(bus.illegal), 16'h0000);
    if (v.we) begin
      checkOutput({t, ".waddr"}, 16'(bus.rf_waddr), 16'(v.instr[11:8]));
      checkOutput({t, ".wdata"}, bus.rf_wdata, v.alu_res);
    end
    @(posedge clk);
    #1;
    checkOutput({t, ".ready_c4"}, 16'(bus.instr_ready), 16'h0001);
    checkOutput({t, ".we_c4"}, 16'(bus.rf_we), 16'h0000);
    checkOutput({t, ".psr"}, 16'(bus.psr), 16'(v.psr));
  endtask

  initial begin
    int acc0;
    int we0;
    int waited;
    int gap;

    //          instr     alu_out   flags     ill   opcode    rdest     rsrc      we    psr
    vecs[0]  = '{16'h0152, 16'h0008, 5'b00000, 1'b0, 5'b00000, 16'h0005, 16'h0003, 1'b1, 5'b00000};
    vecs[1]  = '{16'h53FF, 16'h1233, 5'b10001, 1'b0, 5'b00001, 16'h1234, 16'hFFFF, 1'b1, 5'b00001};
    vecs[2]  = '{16'h63FF, 16'h1333, 5'b01100, 1'b0, 5'b00011, 16'h1234, 16'h00FF, 1'b1, 5'b01100};
    vecs[3]  = '{16'h04B5, 16'h8001, 5'b00011, 1'b0, 5'b01010, 16'h0001, 16'h8000, 1'b0, 5'b00110};
    vecs[4]  = '{16'h0112, 16'h0001, 5'b11111, 1'b0, 5'b01101, 16'h0005, 16'h0003, 1'b1, 5'b00110};
    vecs[5]  = '{16'h8140, 16'h000A, 5'b11111, 1'b0, 5'b10001, 16'h0005, 16'h0005, 1'b1, 5'b00110};
    vecs[6]  = '{16'h9280, 16'h0083, 5'b00101, 1'b0, 5'b01001, 16'h0003, 16'hFF80, 1'b1, 5'b00111};
    vecs[7]  = '{16'h2180, 16'h0085, 5'b11111, 1'b0, 5'b01110, 16'h0005, 16'h0080, 1'b1, 5'b00111};
    vecs[8]  = '{16'hB17F, 16'hFF86, 5'b11000, 1'b0, 5'b01011, 16'h0005, 16'h007F, 1'b0, 5'b11101};
    vecs[9]  = '{16'hF000, 16'hAAAA, 5'b11111, 1'b1, 5'b00000, 16'h0000, 16'h0000, 1'b0, 5'b11101};
    vecs[10] = '{16'h0100, 16'h5555, 5'b00000, 1'b1, 5'b00000, 16'h0000, 16'h0000, 1'b0, 5'b11101};
    vecs[11] = '{16'h8263, 16'h0001, 5'b00000, 1'b0, 5'b10011, 16'h0003, 16'h0003, 1'b1, 5'b11101};
    vecs[12] = '{16'h0193, 16'hEDD1, 5'b00000, 1'b0, 5'b01000, 16'h0005, 16'h1234, 1'b1, 5'b10000};
    vecs[13] = '{16'h3312, 16'h1226, 5'b00000, 1'b0, 5'b01111, 16'h1234, 16'h0012, 1'b1, 5'b10000};

    rst             = 1'b1;
    bus.instr_valid = 1'b0;
    bus.instr       = 16'h0000;
    bus.alu_out     = 16'h0000;
    bus.alu_flags   = 5'b00000;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset.ready", 16'(bus.instr_ready), 16'h0001);
    checkOutput("reset.psr", 16'(bus.psr), 16'h0000);
    checkOutput("reset.we", 16'(bus.rf_we), 16'h0000);
    checkOutput("reset.illegal", 16'(bus.illegal), 16'h0000);
    checkOutput("reset.opcode", 16'(bus.alu_opcode), 16'h0000);
    checkOutput("reset.wdata", bus.rf_wdata, 16'h0000);
    rst = 1'b0;

    for (int i = 0; i < 14; i++) applyStimulus(vecs[i], i);

    // Reset while an ADD is in EXEC: no write-back, psr cleared
    $display("[TB] reset during EXEC");
    we0 = we_count;
    @(negedge clk);
    bus.instr       = 16'h0152;
    bus.alu_out     = 16'h0008;
    bus.alu_flags   = 5'b01101;
    bus.instr_valid = 1'b1;
    @(posedge clk);
    #1 bus.instr_valid = 1'b0;
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    checkOutput("rstexec.ready", 16'(bus.instr_ready), 16'h0001);
    checkOutput("rstexec.psr", 16'(bus.psr), 16'h0000);
    checkOutput("rstexec.we", 16'(bus.rf_we), 16'h0000);
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rstexec.we_pulses", 16'(we_count - we0), 16'h0000);
    checkOutput("rstexec.psr_after", 16'(bus.psr), 16'h0000);

    // instr_valid held high across two ADDs
    $display("[TB] back-to-back with valid held");
    acc0 = accepts;
    we0  = we_count;
    waited = 0;
    @(negedge clk);
    bus.instr       = 16'h0152;
    bus.alu_out     = 16'h0008;
    bus.alu_flags   = 5'b00000;
    bus.instr_valid = 1'b1;
    while (accepts < acc0 + 2 && waited < 30) begin
      @(posedge clk);
      #1;
      waited++;
    end
    bus.instr_valid = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    gap = (accept_cycle.size() >= 2) ? (accept_cycle[$] - accept_cycle[$-1]) : -1;
    checkOutput("b2b.accepts", 16'(accepts - acc0), 16'h0002);
    checkOutput("b2b.gap", 16'(gap), 16'h0004);
    checkOutput("b2b.we_pulses", 16'(we_count - we0), 16'h0002);
    checkOutput("b2b.wdata", bus.rf_wdata, 16'h0008);
    checkOutput("b2b.psr", 16'(bus.psr), 16'h0000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
